seg_to_dec_capture: RTL and testbench
=====================================

Name: seg_to_dec_capture

Overview:
- Receive-side counterpart of the digit-to-HEX encoder. Monitors an 8-bit active-low HEX display bus and decodes it back to a decimal digit.
- Accepts a pattern only after it has been stable for STABLE_CYCLES clocks. Then it emits a one-cycle valid or error pulse.
- Keeps a shift-register history of the last DEPTH digits and a count of digits captured.
- Used in self-check and loopback of the light-show display path.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples needed before a pattern is accepted (legal range 1..255).
- DEPTH, 4, number of decoded digits held in the history register (legal range 1..8).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- display  input  8  active-low segment pattern; bit7 = DP, bits6..0 = g..a.
- digit  output  4  last accepted decimal digit.
- valid  output  1  one-cycle pulse: a legal digit pattern was accepted.
- err  output  1  one-cycle pulse: an illegal, non-blank pattern was accepted.
- history  output  4*DEPTH  last DEPTH digits; newest in [3:0], oldest in the top nibble.
- digit_count  output  8  number of valid pulses, saturating at 255.

Behaviour:
- Decode table, bits6..0 only: 0x40=0, 0x79=1, 0x24=2, 0x30=3, 0x19=4, 0x12=5, 0x02=6, 0x78=7, 0x00=8, 0x10=9.
- Blank pattern (bits6..0 = 0x7F): when accepted, no valid, no err, no state change beyond the lock.
- Any other pattern: illegal.
- Reset (resetn=0 at a rising edge):
  - Sample register s = 8'hFF; counter cnt = 0; state = TRACK.
  - digit = 0, valid = 0, err = 0, history = 0, digit_count = 0.
- Each edge: s <= display.
  - If display == s: cnt <= min(cnt+1, STABLE_CYCLES).
  - Else: cnt <= 0 and state <= TRACK.
- States:
  - TRACK: waiting for stability. On an edge where display == s and cnt == STABLE_CYCLES-1:
    - Legal digit: valid <= 1, digit <= decoded value, history <= {history[4*DEPTH-5:0], value}, digit_count increments with saturation.
    - Illegal pattern: err <= 1.
    - Blank: nothing.
    - In all three cases, state <= LOCKED.
  - LOCKED: no further pulses until display differs from s. That edge returns the block to TRACK with cnt = 0.
- Latency: new pattern present before edge E0 and held → valid/err high for exactly the cycle after edge E(STABLE_CYCLES).
- valid and err are never high together and never wider than one cycle.
- Glitches: a glitch of any length shorter than the stability window restarts the count. A return to the previous pattern after a glitch counts as a new pattern and may re-fire.
- STABLE_CYCLES=1: a pattern fires on the first edge at which it matches the previous sample.
- Reset mid-count or mid-pulse: all outputs clear on that edge. A pattern held through reset is re-accepted after the full window, measured from the first post-reset edge.
- digit_count: holds at 255; history continues to shift.
- digit: holds its last value between pulses; unchanged by err or blank.

Optional Feature:
- Macro SEG_DP_CHECK_EN.
- Defined: bit7 (DP) must be 1 (off) for a pattern to be legal or blank. A DP-on pattern that would otherwise be a digit or blank is treated as illegal and produces err.
- Undefined: bit7 is ignored entirely, including in the stability compare (compare bits6..0 only).

Test Plan:
- Reset, then hold display=8'hF9 with STABLE_CYCLES=4 → valid high for one cycle after the 4th edge, digit=1, history[3:0]=1, digit_count=1; no further pulse while held.
- Sequence 0xC0, 0xA4, 0xB0, 0x99, each held 6 cycles, DEPTH=4 → history=16'h0234 after the 4th valid (0xC0=0 shifted to the top nibble), digit_count=4.
- Hold 0xA4 for 3 cycles, 1 cycle of 0x80, 0xA4 again for 5 cycles → no pulse during the first 0xA4 or the 0x80; exactly one valid with digit=2.
- Hold 0xFF (blank), then 0x7F (illegal under the macro, blank without it), then 0xAA → blank gives no pulse; 0xAA gives err=1 with digit unchanged; check 0x7F under both macro settings.
- Assert resetn=0 in the cycle before an expected valid, with 0x90 held → no pulse; all outputs 0; valid (digit=9) fires 4 edges after the reset release edge.
- 256 distinct accepted digits → digit_count saturates at 255; history still updates.

Source files
------------

// File: rtl/seg_to_dec_capture.sv
// Decodes an active-low 7-segment (+DP) bus back to a decimal digit once the pattern is stable.
// Define SEG_DP_CHECK_EN to require DP off for legal/blank patterns and to include DP in the stability compare.
module seg_to_dec_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         display,
  output logic [3:0]         digit,
  output logic               valid,
  output logic               err,
  output logic [4*DEPTH-1:0] history,
  output logic [7:0]         digit_count
);

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 1);
`ifdef SEG_DP_CHECK_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

  typedef enum logic {TRACK, LOCKED} state_t;

  state_t               r_state;
  logic [7:0]           r_sample;
  logic [7:0]           r_cnt;
  logic                 w_same;
  logic                 w_legal;
  logic                 w_blank;
  logic [3:0]           w_value;
  logic [4*DEPTH-1:0]   w_hist_next;

  // Returns {legal, value} for the segment bits g..a.
  function automatic logic [4:0] decode7(input logic [6:0] seg);
    case (seg)
      7'h40:   decode7 = 5'h10;
      7'h79:   decode7 = 5'h11;
      7'h24:   decode7 = 5'h12;
      7'h30:   decode7 = 5'h13;
      7'h19:   decode7 = 5'h14;
      7'h12:   decode7 = 5'h15;
      7'h02:   decode7 = 5'h16;
      7'h78:   decode7 = 5'h17;
      7'h00:   decode7 = 5'h18;
      7'h10:   decode7 = 5'h19;
      default: decode7 = 5'h00;
    endcase
  endfunction

  always_comb begin
    w_same              = ((display ^ r_sample) & CMP_MASK) == 8'h00;
    {w_legal, w_value}  = decode7(display[6:0]);
    w_blank             = (display[6:0] == 7'h7F);
`ifdef SEG_DP_CHECK_EN
    // A lit decimal point disqualifies both digits and blank.
    if (!display[7]) begin
      w_legal = 1'b0;
      w_blank = 1'b0;
    end
`endif
  end

  generate
    if (DEPTH == 1) begin : g_hist1
      assign w_hist_next = w_value;
    end else begin : g_histn
      assign w_hist_next = {history[4*DEPTH-5:0], w_value};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= TRACK;
      r_sample    <= 8'hFF;
      r_cnt       <= 8'd0;
      digit       <= 4'd0;
      valid       <= 1'b0;
      err         <= 1'b0;
      history     <= '0;
      digit_count <= 8'd0;
    end else begin
      valid    <= 1'b0;
      err      <= 1'b0;
      r_sample <= display;
      if (w_same) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 8'd1;
        if (r_state == TRACK && r_cnt == CNT_FIRE) begin
          r_state <= LOCKED;
          if (w_legal) begin
            valid   <= 1'b1;
            digit   <= w_value;
            history <= w_hist_next;
            if (digit_count != 8'hFF) digit_count <= digit_count + 8'd1;
          end else if (!w_blank) begin
            err <= 1'b1;
          end
        end
      end else begin
        r_cnt   <= 8'd0;
        r_state <= TRACK;
      end
    end
  end

endmodule

// File: tb/tb_seg_to_dec_capture.sv
// Scoreboard bench for seg_to_dec_capture: run-length reference model feeds an expected-pulse queue.
module tb_seg_to_dec_capture;
  localparam int SC = 4;
  localparam int DP = 4;
`ifdef SEG_DP_CHECK_EN
  localparam logic [7:0] MASK  = 8'hFF;
  localparam bit         DPCHK = 1'b1;
`else
  localparam logic [7:0] MASK  = 8'h7F;
  localparam bit         DPCHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [7:0]      display = 8'hFF;
  logic [3:0]      digit;
  logic            valid;
  logic            err;
  logic [4*DP-1:0] history;
  logic [7:0]      digit_count;

  always #5 clk = ~clk;

  seg_to_dec_capture #(.STABLE_CYCLES(SC), .DEPTH(DP)) dut (
    .clk(clk), .resetn(resetn), .display(display), .digit(digit), .valid(valid),
    .err(err), .history(history), .digit_count(digit_count)
  );

  logic [6:0] SEGS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    int              cyc;
    bit              is_err;
    logic [3:0]      dig;
    logic [4*DP-1:0] hist;
    logic [7:0]      cnt;
  } exp_t;

  exp_t       expq[$];
  int         acc[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] m_last = 8'hFF;
  int         m_run = 1;
  logic [3:0] m_digit = 4'd0;

  // 0..9 digit, 10 blank, 11 illegal
  function automatic int classify(input logic [7:0] p);
    if (DPCHK && !p[7]) return 11;
    if (p[6:0] == 7'h7F) return 10;
    for (int i = 0; i < 10; i++) if (SEGS[i] == p[6:0]) return i;
    return 11;
  endfunction

  function automatic logic [4*DP-1:0] model_hist();
    logic [4*DP-1:0] h = '0;
    for (int k = 0; k < DP; k++) begin
      int idx = acc.size() - 1 - k;
      if (idx >= 0) h[4*k +: 4] = 4'(acc[idx]);
    end
    return h;
  endfunction

  function automatic logic [7:0] model_count();
    return (acc.size() > 255) ? 8'd255 : 8'(acc.size());
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a pattern fires when the run of identical masked samples
  // (the reset value counts as a sample) reaches SC+1.
  always @(posedge clk) begin
    logic [7:0] x;
    int c;
    exp_t e;
    cyc++;
    if (!resetn) begin
      m_last  = 8'hFF & MASK;
      m_run   = 1;
      acc.delete();
      m_digit = 4'd0;
    end else begin
      x = display & MASK;
      if (x == m_last) m_run++;
      else begin
        m_last = x;
        m_run  = 1;
      end
      if (m_run == SC + 1) begin
        c = classify(display);
        if (c < 10) begin
          acc.push_back(c);
          m_digit = 4'(c);
        end
        if (c != 10) begin
          e.cyc = cyc; e.is_err = (c == 11); e.dig = m_digit;
          e.hist = model_hist(); e.cnt = model_count();
          expq.push_back(e);
        end
      end
    end
  end

  // Monitor: pops expected pulses when the DUT presents one.
  always @(negedge clk) begin
    exp_t e;
    check("valid_err_exclusive", {31'd0, valid & err}, 32'd0);
    if (valid || err) begin
      if (expq.size() == 0) check("unexpected_pulse", {31'd0, valid}, {31'd0, err});
      else begin
        e = expq.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_is_err", {31'd0, err}, {31'd0, e.is_err});
        check("pulse_digit", {28'd0, digit}, {28'd0, e.dig});
        check("pulse_history", {16'd0, history}, {16'd0, e.hist});
        check("pulse_count", {24'd0, digit_count}, {24'd0, e.cnt});
      end
    end
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      e = expq.pop_front();
      check("missed_pulse_at_cycle", 32'd0, e.cyc);
    end
    check("hold_digit", {28'd0, digit}, {28'd0, m_digit});
    check("hold_history", {16'd0, history}, {16'd0, model_hist()});
    check("hold_count", {24'd0, digit_count}, {24'd0, model_count()});
  end

  task automatic hold(input logic [7:0] p, input int n);
    display = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_digit"}, {28'd0, digit}, 32'd0);
    check({tag, "_history"}, {16'd0, history}, 32'd0);
    check({tag, "_count"}, {24'd0, digit_count}, 32'd0);
  endtask

  initial begin
    logic [7:0] p;
    int r;
    resetn  = 1'b0;
    display = 8'hFF;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    resetn = 1'b1;

    hold(8'hF9, 10);
    check("single_digit", {28'd0, digit}, 32'd1);
    check("single_count", {24'd0, digit_count}, 32'd1);

    hold(8'hC0, 6); hold(8'hA4, 6); hold(8'hB0, 6); hold(8'h99, 6);
    check("seq_history", {16'd0, history}, 32'h0234);
    check("seq_count", {24'd0, digit_count}, 32'd5);

    hold(8'hA4, 3); hold(8'h80, 1); hold(8'hA4, 5);
    check("glitch_digit", {28'd0, digit}, 32'd2);
    check("glitch_count", {24'd0, digit_count}, 32'd6);

    hold(8'hFF, 6); hold(8'h7F, 6); hold(8'hAA, 6);
    check("err_digit_kept", {28'd0, digit}, 32'd2);

    display = 8'h90;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_cleared("midreset");
    resetn = 1'b1;
    hold(8'h90, 6);
    check("post_reset_digit", {28'd0, digit}, 32'd9);
    check("post_reset_count", {24'd0, digit_count}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) p = {($urandom_range(0, 9) != 0), SEGS[$urandom_range(0, 9)]};
      else if (r < 75) p = {($urandom_range(0, 3) != 0), 7'h7F};
      else p = 8'($urandom);
      if ($urandom_range(0, 99) < 3) resetn = 1'b0;
      hold(p, int'($urandom_range(1, 7)));
      resetn = 1'b1;
    end

    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 260; i++) hold({1'b1, SEGS[i % 10]}, SC + 1);
    check("sat_count", {24'd0, digit_count}, 32'd255);
    check("sat_history", {16'd0, history}, 32'h6789);

    display = 8'hFF;
    repeat (8) @(negedge clk);
    check("queue_drained", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
